// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter over the range 1..R with wrap/saturate modes,
// parallel load, registered terminal flag, event pulses and a saturating wrap counter.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [NUM_CNT_BITS-1:0]  load_val_i,
    input  logic                     count_enable_i,
    input  logic                     count_down_i,
    input  logic                     sat_mode_i,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val_i,
    output logic [NUM_CNT_BITS-1:0]  count_out_o,
    output logic                     rollover_flag_o,
    output logic                     wrap_pulse_o,
    output logic                     sat_flag_o,
    output logic [WRAP_CNT_BITS-1:0] wrap_count_o
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0]  count_q, count_d;
    logic                     rollover_q, rollover_d;
    logic                     wrap_pulse_q, wrap_pulse_d;
    logic                     sat_flag_q, sat_flag_d;
    logic [WRAP_CNT_BITS-1:0] wrap_count_q, wrap_count_d;
    logic                     range_ok;
    logic [NUM_CNT_BITS-1:0]  terminal;

    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        sat_flag_d   = 1'b0;
        range_ok     = (rollover_val_i != '0);

        if (load_i) begin
            count_d = load_val_i;
        end else if (count_enable_i && range_ok) begin
            if (!count_down_i) begin
                if (count_q < rollover_val_i) begin
                    count_d = count_q + ONE;
                end else if (sat_mode_i) begin
                    count_d    = rollover_val_i;
                    sat_flag_d = 1'b1;
                end else begin
                    count_d      = ONE;
                    wrap_pulse_d = 1'b1;
                end
            end else begin
                // A count above R (R lowered) snaps back into range without an event.
                if (count_q > rollover_val_i) begin
                    count_d = rollover_val_i;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else if (sat_mode_i) begin
                    count_d    = ONE;
                    sat_flag_d = 1'b1;
                end else begin
                    count_d      = rollover_val_i;
                    wrap_pulse_d = 1'b1;
                end
            end
        end

        terminal   = count_down_i ? ONE : rollover_val_i;
        rollover_d = range_ok && (count_d == terminal);

        wrap_count_d = wrap_count_q;
        if (wrap_pulse_d && (wrap_count_q != '1)) begin
            wrap_count_d = wrap_count_q + WRAP_CNT_BITS'(1);
        end

        if (clear_i) begin
            count_d      = '0;
            rollover_d   = 1'b0;
            wrap_pulse_d = 1'b0;
            sat_flag_d   = 1'b0;
            wrap_count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= '0;
            rollover_q   <= 1'b0;
            wrap_pulse_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            count_q      <= count_d;
            rollover_q   <= rollover_d;
            wrap_pulse_q <= wrap_pulse_d;
            sat_flag_q   <= sat_flag_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign count_out_o     = count_q;
    assign rollover_flag_o = rollover_q;
    assign wrap_pulse_o    = wrap_pulse_q;
    assign sat_flag_o      = sat_flag_q;
    assign wrap_count_o    = wrap_count_q;

endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed plus randomized bench for flex_counter_ud, checked against an
// integer reference model of the counting rules.
module tb_flex_counter_ud;

    localparam int NB = 4;
    localparam int WB = 2;
    localparam int WC_MAX = (1 << WB) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          load_i = 1'b0;
    logic [NB-1:0] load_val_i = '0;
    logic          count_enable_i = 1'b0;
    logic          count_down_i = 1'b0;
    logic          sat_mode_i = 1'b0;
    logic [NB-1:0] rollover_val_i = '0;
    logic [NB-1:0] count_out_o;
    logic          rollover_flag_o;
    logic          wrap_pulse_o;
    logic          sat_flag_o;
    logic [WB-1:0] wrap_count_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_cnt = 0, m_roll = 0, m_wp = 0, m_sf = 0, m_wc = 0;

    flex_counter_ud #(.NUM_CNT_BITS(NB), .WRAP_CNT_BITS(WB)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .load_i         (load_i),
        .load_val_i     (load_val_i),
        .count_enable_i (count_enable_i),
        .count_down_i   (count_down_i),
        .sat_mode_i     (sat_mode_i),
        .rollover_val_i (rollover_val_i),
        .count_out_o    (count_out_o),
        .rollover_flag_o(rollover_flag_o),
        .wrap_pulse_o   (wrap_pulse_o),
        .sat_flag_o     (sat_flag_o),
        .wrap_count_o   (wrap_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Next state from the rules with plain integers; inputs are those present at the edge.
    task automatic model_step();
        int r, term;
        r = int'(rollover_val_i);
        if (rst_i || clear_i) begin
            m_cnt = 0; m_roll = 0; m_wp = 0; m_sf = 0; m_wc = 0;
            return;
        end
        m_wp = 0;
        m_sf = 0;
        if (load_i) begin
            m_cnt = int'(load_val_i);
        end else if (count_enable_i && r != 0) begin
            if (!count_down_i) begin
                if (m_cnt < r)        m_cnt = m_cnt + 1;
                else if (sat_mode_i)  begin m_cnt = r; m_sf = 1; end
                else                  begin m_cnt = 1; m_wp = 1; end
            end else begin
                if (m_cnt > r)        m_cnt = r;
                else if (m_cnt > 1)   m_cnt = m_cnt - 1;
                else if (sat_mode_i)  begin m_cnt = 1; m_sf = 1; end
                else                  begin m_cnt = r; m_wp = 1; end
            end
            if (m_wp == 1 && m_wc < WC_MAX) m_wc = m_wc + 1;
        end
        term = count_down_i ? 1 : r;
        m_roll = (r != 0 && m_cnt == term) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        chk("count_out",     int'(count_out_o),     m_cnt);
        chk("rollover_flag", int'(rollover_flag_o), m_roll);
        chk("wrap_pulse",    int'(wrap_pulse_o),    m_wp);
        chk("sat_flag",      int'(sat_flag_o),      m_sf);
        chk("wrap_count",    int'(wrap_count_o),    m_wc);
    endtask

    task automatic idle_inputs();
        rst_i = 0; clear_i = 0; load_i = 0; load_val_i = '0;
        count_enable_i = 0; count_down_i = 0; sat_mode_i = 0;
    endtask

    initial begin
        // reset with enable and load asserted
        idle_inputs();
        rst_i = 1; count_enable_i = 1; load_i = 1; load_val_i = 4'd7; rollover_val_i = 4'd5;
        tick(); tick();
        chk("reset_count", int'(count_out_o), 0);
        chk("reset_wc",    int'(wrap_count_o), 0);

        // up wrap with R=5 over 11 enabled cycles
        idle_inputs();
        count_enable_i = 1;
        tick();
        chk("first_step", int'(count_out_o), 1);
        for (int i = 2; i <= 11; i++) begin
            tick();
            if (i == 5 || i == 10) chk("upwrap_roll", int'(rollover_flag_o), 1);
            if (i == 6)            chk("upwrap_pulse6", int'(wrap_pulse_o), 1);
        end
        chk("upwrap_end_count", int'(count_out_o), 1);
        chk("upwrap_end_pulse", int'(wrap_pulse_o), 1);
        chk("upwrap_end_wc",    int'(wrap_count_o), 2);

        // down saturate from 3
        idle_inputs();
        load_i = 1; load_val_i = 4'd3;
        tick();
        idle_inputs();
        count_down_i = 1; sat_mode_i = 1; count_enable_i = 1;
        tick(); tick();
        chk("downsat_roll", int'(rollover_flag_o), 1);
        tick(); tick();
        chk("downsat_count", int'(count_out_o), 1);
        chk("downsat_sf",    int'(sat_flag_o), 1);

        // priority clear > load > enable
        idle_inputs();
        clear_i = 1; load_i = 1; load_val_i = 4'd7; count_enable_i = 1;
        tick();
        chk("prio_clear", int'(count_out_o), 0);
        clear_i = 0;
        tick();
        chk("prio_load", int'(count_out_o), 7);
        chk("prio_load_wp", int'(wrap_pulse_o), 0);

        // range lowered below the current count
        idle_inputs();
        rollover_val_i = 4'd10; load_i = 1; load_val_i = 4'd9;
        tick();
        idle_inputs();
        rollover_val_i = 4'd6; count_enable_i = 1;
        tick();
        chk("range_wrap_count", int'(count_out_o), 1);
        chk("range_wrap_wp",    int'(wrap_pulse_o), 1);
        idle_inputs();
        load_i = 1; load_val_i = 4'd9;
        tick();
        idle_inputs();
        sat_mode_i = 1; count_enable_i = 1;
        tick();
        chk("range_sat_count", int'(count_out_o), 6);
        chk("range_sat_sf",    int'(sat_flag_o), 1);

        // R=0 holds, but load still applies
        idle_inputs();
        rollover_val_i = 4'd0; count_enable_i = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("r0_hold", int'(count_out_o), 6);
        load_i = 1; load_val_i = 4'd7;
        tick();
        chk("r0_load", int'(count_out_o), 7);

        // wrap_count saturation with R=1
        idle_inputs();
        clear_i = 1;
        tick();
        idle_inputs();
        rollover_val_i = 4'd1; count_enable_i = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("wc_sat", int'(wrap_count_o), 3);
        chk("wc_sat_wp", int'(wrap_pulse_o), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_i          = ($urandom_range(0, 199) == 0);
            clear_i        = ($urandom_range(0, 99) == 0);
            load_i         = ($urandom_range(0, 9) == 0);
            load_val_i     = NB'($urandom);
            count_enable_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) count_down_i = ~count_down_i;
            if ($urandom_range(0, 15) == 0) sat_mode_i = ~sat_mode_i;
            if ($urandom_range(0, 31) == 0) rollover_val_i = NB'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/flex_counter_ud.md
# flex_counter_ud

Parametrised up/down flexible counter for the UART receiver and timer paths, and the general-purpose counter for new blocks. It adds to the basic flex counter: direction control, wrap or saturate mode, synchronous parallel load, a one-cycle wrap pulse, a saturation flag and a saturating wrap-event counter. Every output is registered, and the block runs in a single clock domain.

## Interface
- NUM_CNT_BITS, 4, width of count_out, rollover_val and load_val
- WRAP_CNT_BITS, 8, width of wrap_count
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- clear  in  1  synchronous clear of count_out, flags and wrap_count
- load  in  1  synchronous parallel load of load_val
- load_val  in  NUM_CNT_BITS  value loaded when load=1
- count_enable  in  1  advance counter one step this cycle
- count_down  in  1  0 = count up, 1 = count down
- sat_mode  in  1  0 = wrap at terminal, 1 = hold at terminal
- rollover_val  in  NUM_CNT_BITS  upper bound R of the count range (1..R)
- count_out  out  NUM_CNT_BITS  current count
- rollover_flag  out  1  high while count_out equals the terminal value
- wrap_pulse  out  1  one-cycle pulse after a wrap
- sat_flag  out  1  one-cycle pulse after an enabled step blocked by saturation
- wrap_count  out  WRAP_CNT_BITS  number of wraps since clear/reset, saturating at all-ones

## Operation
- Priority per cycle: rst > clear > load > count_enable > hold.
- rst or clear: count_out=0, rollover_flag=0, wrap_pulse=0, sat_flag=0, wrap_count=0.
- load: count_out=load_val, with no range check. wrap_pulse and sat_flag are 0. wrap_count is unchanged. load still applies when R=0.
- R=0: count_enable is ignored and count_out holds. rollover_flag, wrap_pulse and sat_flag are 0.
- Terminal value T: T=R when counting up, T=1 when counting down.
- Up, enabled:
  - count_out < R: count_out+1.
  - count_out >= R, wrap mode: next count is 1, wrap_pulse=1 next cycle, wrap_count+1.
  - count_out >= R, sat mode: next count is R, sat_flag=1 next cycle.
- Down, enabled:
  - count_out > R: next count is R, with no wrap or sat event.
  - 1 < count_out <= R: count_out-1.
  - count_out <= 1, wrap mode: next count is R, wrap_pulse=1, wrap_count+1.
  - count_out <= 1, sat mode: next count is 1, sat_flag=1.
- Out-of-range recovery: a count of 0 after reset, or a count above R after R is lowered, is handled by the compare rules above.
- count_out+1 never overflows NUM_CNT_BITS, because the increment only occurs when count_out < R.
- wrap_count saturates at 2^WRAP_CNT_BITS-1. Further wraps still pulse wrap_pulse.
- rollover_flag is registered as (next count_out == T) && R!=0, where T uses the count_down and rollover_val sampled in the same cycle. It therefore tracks count_out with no lag while direction and R are stable. A change to count_down or rollover_val while the counter is held updates the flag on the next edge.

## Timing
- Every output changes only on the rising edge of clk.
- Inputs are sampled on that edge, so an action becomes visible one cycle later.
- wrap_pulse and sat_flag are high for exactly one cycle per event. Consecutive events give consecutive high cycles (e.g. sat mode held with enable=1).
- wrap_pulse goes high in the same cycle count_out shows its post-wrap value.
- Reset mid-count takes effect on the next edge regardless of every other input.
- No combinational path exists from any input to any output.

## Test plan
- Reset: rst=1 for 2 cycles with count_enable=1 and load=1 -> count_out=0, all flags 0, wrap_count=0. Then release rst with R=5 and enable -> count_out=1 on the first edge.
- Up wrap: R=5, NUM_CNT_BITS=4, enable for 11 cycles from 0 -> count_out 1,2,3,4,5,1,2,3,4,5,1. rollover_flag is high on both 5s. wrap_pulse is high on cycles 6 and 11. wrap_count=2.
- Down saturate: load 3, then count_down=1, sat_mode=1, enable 4 cycles -> count_out 2,1,1,1. rollover_flag is high from the first 1. sat_flag is high on cycles 3 and 4. wrap_count stays 0.
- Priority: clear=1, load=1, load_val=7 and enable all in one cycle -> count_out=0. Next cycle load=1 with enable=1 -> count_out=7, wrap_pulse=0.
- Range change: count_out=9, R lowered to 6, up, enable. In wrap mode -> count_out=1, wrap_pulse=1. In sat mode -> count_out=6, sat_flag=1.
- Degenerate and saturation limits:
  - R=0 with enable for 5 cycles -> count_out holds and flags stay 0. load_val=7 still loads 7.
  - WRAP_CNT_BITS=2, R=1, up wrap, enable 6 cycles -> wrap_count reaches 3 and holds while wrap_pulse stays high.
